// File: rtl/dot_product_seq_pkg.sv
// Shared definitions for the sequential dot-product block: default operand,
// accumulator and beat-counter widths, plus the two-state FSM encoding.
package dot_product_seq_pkg;

  localparam int DEF_A_WIDTH   = 16;
  localparam int DEF_B_WIDTH   = 16;
  localparam int DEF_ACC_WIDTH = DEF_A_WIDTH + DEF_B_WIDTH;
  localparam int DEF_CNT_WIDTH = 16;

  // ST_ACC accepts operand pairs, ST_HOLD presents the finished result.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage : dot_product_seq_pkg

// File: rtl/dot_product_seq_mac_unit.sv
// Combinational multiply-add: result = addend + a*b, truncated to ACC_WIDTH.
// The full-width product is formed first so the multiply never loses bits
// before the final truncation to the accumulator width.
module dot_product_seq_mac_unit
  import dot_product_seq_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int ACC_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic [ACC_WIDTH-1:0] addend,
  output logic [ACC_WIDTH-1:0] result
);

  localparam int PROD_WIDTH = A_WIDTH + B_WIDTH;

  logic [PROD_WIDTH-1:0] product;

  // Unsigned product at full precision, then wrap-around add into the accumulator.
  always_comb begin
    product = PROD_WIDTH'(a) * PROD_WIDTH'(b);
    result  = addend + ACC_WIDTH'(product);
  end

endmodule : dot_product_seq_mac_unit

// File: rtl/dot_product_seq.sv
// Sequential dot product: accumulates a*b over a stream of operand pairs
// terminated by in_last, then holds the sum, pair count and a sticky wrap
// flag until the consumer takes them. One bubble separates vectors because
// the result handshake cycle never accepts a new pair.
module dot_product_seq
  import dot_product_seq_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int ACC_WIDTH = A_WIDTH + B_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_result,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_overflow
);

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   ovf_q, ovf_d;

  logic [ACC_WIDTH-1:0]   mac_sum;
  logic                   beat;
  logic                   result_take;

  dot_product_seq_mac_unit #(
    .A_WIDTH   (A_WIDTH),
    .B_WIDTH   (B_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .a      (in_a),
    .b      (in_b),
    .addend (acc_q),
    .result (mac_sum)
  );

  // Handshake qualifiers are decoded from the registered state only.
  always_comb begin
    beat        = in_valid && (state_q == ST_ACC);
    result_take = out_ready && (state_q == ST_HOLD);
  end

  // Every register of the block, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: last accepted beat moves to HOLD, result handshake returns to ACC.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACC:  if (beat && in_last) state_d = ST_HOLD;
      ST_HOLD: if (result_take)     state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  // Datapath: accumulate on a beat, clear everything when the result is taken.
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (beat) begin
      acc_d   = mac_sum;
      count_d = (count_q == '1) ? count_q : count_q + CNT_WIDTH'(1);
      ovf_d   = ovf_q | (mac_sum < acc_q);
    end else if (result_take) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end
  end

  // Outputs: ready/valid from state, result fields show the running registers.
  always_comb begin
    in_ready     = (state_q == ST_ACC);
    out_valid    = (state_q == ST_HOLD);
    out_result   = acc_q;
    out_count    = count_q;
    out_overflow = ovf_q;
  end

endmodule : dot_product_seq
